// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, FSM states and operand-signedness helpers for muldiv_unit
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between the execute stage and muldiv_unit
interface muldiv_unit_if;
    import muldiv_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            flush;
    logic            ready;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_in, flush,
        input  ready, done, result, rd_out
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_in, flush,
        output ready, done, result, rd_out
    );

endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide, fixed 33-cycle latency, start/done handshake
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_unit_if.slave   bus
);
    import muldiv_pkg::*;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_funct3;
    logic                r_sign_a;
    logic                r_sign_b;
    logic [XLEN-1:0]     r_a_mag;
    logic [XLEN-1:0]     r_b_mag;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_quo;
    logic                r_done;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rd_out;

    logic                w_accept;
    logic                w_last;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_rem_sh;
    logic                w_qbit;
    logic [XLEN-1:0]     w_diff;
    logic [2*XLEN-1:0]   w_acc_nxt;
    logic [XLEN-1:0]     w_quo_nxt;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo_f;
    logic [XLEN-1:0]     w_rem_f;
    logic [XLEN-1:0]     w_a_val;
    logic                w_div0;
    logic                w_ovf;
    logic [XLEN-1:0]     w_fix;

    assign w_accept = bus.start && !bus.flush && (r_state == IDLE);
    assign w_last   = (r_state == CALC) && (r_cnt == '1);

    assign w_neg_a = is_signed_a(bus.funct3) && bus.rs1_data[XLEN-1];
    assign w_neg_b = is_signed_b(bus.funct3) && bus.rs2_data[XLEN-1];
    assign w_mag_a = w_neg_a ? -bus.rs1_data : bus.rs1_data;
    assign w_mag_b = w_neg_b ? -bus.rs2_data : bus.rs2_data;

    // Multiply: acc = {partial product, remaining multiplier bits}; the carry re-enters on the right shift.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a_mag} : '0);

    // Divide: acc = {remainder, dividend bits not yet consumed}; shifted remainder needs one extra bit.
    assign w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
    assign w_qbit   = (w_rem_sh >= {1'b0, r_b_mag});
    assign w_diff   = w_rem_sh[XLEN-1:0] - r_b_mag;

    always_comb begin
        w_acc_nxt = r_acc;
        w_quo_nxt = r_quo;
        if (r_funct3[2]) begin
            w_acc_nxt = {(w_qbit ? w_diff : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], 1'b0};
            w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};
        end else begin
            w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
        end
    end

    assign w_prod  = (r_sign_a ^ r_sign_b) ? -w_acc_nxt : w_acc_nxt;
    assign w_quo_f = (r_sign_a ^ r_sign_b) ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_f = r_sign_a ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
    assign w_a_val = r_sign_a ? -r_a_mag : r_a_mag;
    assign w_div0  = (r_b_mag == '0);
    assign w_ovf   = r_sign_a && r_sign_b && (r_a_mag == {1'b1, {(XLEN-1){1'b0}}})
                     && (r_b_mag == XLEN'(1));

    always_comb begin
        w_fix = '0;
        case (r_funct3)
            F3_MUL:                        w_fix = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  w_fix = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU: begin
                if (w_div0)     w_fix = '1;
                else if (w_ovf) w_fix = {1'b1, {(XLEN-1){1'b0}}};
                else            w_fix = w_quo_f;
            end
            default: begin
                if (w_div0)     w_fix = w_a_val;
                else if (w_ovf) w_fix = '0;
                else            w_fix = w_rem_f;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = CALC;
            CALC: begin
                if (bus.flush)   w_state_nxt = IDLE;
                else if (w_last) w_state_nxt = FIN;
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The fixed-up value is captured on the last CALC edge so result/done are registered in FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a_mag  <= '0;
            r_b_mag  <= '0;
            r_acc    <= '0;
            r_quo    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt    <= '0;
                r_funct3 <= bus.funct3;
                r_sign_a <= w_neg_a;
                r_sign_b <= w_neg_b;
                r_a_mag  <= w_mag_a;
                r_b_mag  <= w_mag_b;
                r_acc    <= bus.funct3[2] ? {{XLEN{1'b0}}, w_mag_a} : {{XLEN{1'b0}}, w_mag_b};
                r_quo    <= '0;
                r_rd_out <= bus.rd_in;
            end else if (r_state == CALC && !bus.flush) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_acc <= w_acc_nxt;
                r_quo <= w_quo_nxt;
                if (w_last) begin
                    r_done   <= 1'b1;
                    r_result <= w_fix;
                end
            end
        end
    end

    assign bus.ready  = (r_state == IDLE);
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector table plus control/reset sequences for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 18;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_tot;
    vec_t vecs[NV];

    muldiv_unit_if bus();

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic wait_ready(input string nm);
        for (int i = 0; i < 60 && bus.ready !== 1'b1; i++) @(negedge clk);
        if (bus.ready !== 1'b1) chk({nm, " ready_wait"}, 32'(bus.ready), 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input string nm);
        int          done_at;
        int          n_done;
        bit          rdy_ok;
        logic [31:0] res;
        logic [4:0]  rdo;
        wait_ready(nm);
        bus.funct3 = f3; bus.rs1_data = a; bus.rs2_data = b; bus.rd_in = rd;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        done_at = 0; n_done = 0; rdy_ok = 1'b1; res = '0; rdo = '0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (done_at == 0) begin
                    done_at = k; res = bus.result; rdo = bus.rd_out;
                end
            end
            if (k <= 33 && bus.ready) rdy_ok = 1'b0;
            if (k == 34 && !bus.ready) rdy_ok = 1'b0;
        end
        chk({nm, " result"},   res, exp);
        chk({nm, " latency"},  32'(done_at), 32'd33);
        chk({nm, " pulses"},   32'(n_done), 32'd1);
        chk({nm, " ready"},    32'(rdy_ok), 32'd1);
        chk({nm, " rd_out"},   32'(rdo), 32'(rd));
        chk({nm, " hold"},     bus.result, exp);
    endtask

    initial begin
        n_pass = 0; n_tot = 0;
        vecs[0]  = '{F3_MUL,    32'd7,         32'hFFFF_FFFD, 5'd13, 32'hFFFF_FFEB};
        vecs[1]  = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
        vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
        vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
        vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD};
        vecs[5]  = '{F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF};
        vecs[6]  = '{F3_DIVU,   32'd100,       32'd7,         5'd6,  32'd14};
        vecs[7]  = '{F3_REMU,   32'd100,       32'd7,         5'd7,  32'd2};
        vecs[8]  = '{F3_DIVU,   32'd5,         32'd0,         5'd8,  32'hFFFF_FFFF};
        vecs[9]  = '{F3_REMU,   32'd5,         32'd0,         5'd9,  32'd5};
        vecs[10] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000};
        vecs[11] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0};
        vecs[12] = '{F3_DIV,    32'd20,        32'hFFFF_FFFD, 5'd12, 32'hFFFF_FFFA};
        vecs[13] = '{F3_REM,    32'd20,        32'hFFFF_FFFD, 5'd14, 32'd2};
        vecs[14] = '{F3_REM,    32'hFFFF_FFF9, 32'd0,         5'd15, 32'hFFFF_FFF9};
        vecs[15] = '{F3_DIV,    32'h8000_0000, 32'd0,         5'd16, 32'hFFFF_FFFF};
        vecs[16] = '{F3_MUL,    32'h1234_5678, 32'h10,        5'd17, 32'h2345_6780};
        vecs[17] = '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'd0};

        bus.start = 1'b0; bus.funct3 = '0; bus.rs1_data = '0; bus.rs2_data = '0;
        bus.rd_in = '0; bus.flush = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset done",   32'(bus.done), 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset rd_out", 32'(bus.rd_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset ready", 32'(bus.ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp,
                   $sformatf("vec%0d", i));
        end

        // flush 10 cycles after accept
        begin
            int n_done;
            logic [31:0] prev;
            prev = bus.result;
            wait_ready("flush");
            bus.funct3 = F3_MUL; bus.rs1_data = 32'd5; bus.rs2_data = 32'd5; bus.rd_in = 5'd3;
            bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            repeat (10) @(negedge clk);
            bus.flush = 1'b1;
            @(posedge clk);
            #1 bus.flush = 1'b0;
            @(negedge clk);
            chk("flush ready", 32'(bus.ready), 32'd1);
            n_done = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.done) n_done++;
            end
            chk("flush no_done", 32'(n_done), 32'd0);
            chk("flush result_kept", bus.result, prev);
        end

        // flush and start together in IDLE
        begin
            int n_done;
            bus.funct3 = F3_MUL; bus.rs1_data = 32'd9; bus.rs2_data = 32'd9; bus.rd_in = 5'd4;
            bus.start = 1'b1; bus.flush = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0; bus.flush = 1'b0;
            @(negedge clk);
            chk("flush_start ready", 32'(bus.ready), 32'd1);
            n_done = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.done) n_done++;
            end
            chk("flush_start no_done", 32'(n_done), 32'd0);
        end

        // start pulsed while busy
        begin
            int n_done;
            int done_at;
            logic [31:0] res;
            wait_ready("busy");
            bus.funct3 = F3_MUL; bus.rs1_data = 32'd3; bus.rs2_data = 32'd5; bus.rd_in = 5'd7;
            bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            n_done = 0; done_at = 0; res = '0;
            for (int k = 1; k <= 75; k++) begin
                @(negedge clk);
                if (k == 5) begin
                    bus.funct3 = F3_DIVU; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7;
                    bus.rd_in = 5'd20; bus.start = 1'b1;
                end
                if (k == 6) bus.start = 1'b0;
                if (bus.done) begin
                    n_done++;
                    if (done_at == 0) begin
                        done_at = k; res = bus.result;
                    end
                end
            end
            chk("busy pulses",  32'(n_done), 32'd1);
            chk("busy latency", 32'(done_at), 32'd33);
            chk("busy result",  res, 32'd15);
            chk("busy rd_out",  32'(bus.rd_out), 32'd7);
        end

        // async reset mid-CALC
        begin
            int n_done;
            wait_ready("rst");
            bus.funct3 = F3_MUL; bus.rs1_data = 32'd7; bus.rs2_data = 32'd9; bus.rd_in = 5'd9;
            bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            repeat (12) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("rst done",   32'(bus.done), 32'd0);
            chk("rst result", bus.result, 32'd0);
            chk("rst rd_out", 32'(bus.rd_out), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("rst ready", 32'(bus.ready), 32'd1);
            n_done = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.done) n_done++;
            end
            chk("rst no_done", 32'(n_done), 32'd0);
            run_op(F3_MUL, 32'd3, 32'd4, 5'd21, 32'd12, "post_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
